// File: rtl/commit_trace_pkg.sv
// rtl/commit_trace_pkg.sv - shared kind codes, FSM states and record layout for the commit trace buffer
package commit_trace_pkg;

  localparam int KIND_W = 3;

  typedef enum logic [KIND_W-1:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_STU  = 3'd4,
    KIND_HALT = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Record is {inum, cycle, kind, pc, wreg, wdata, addr, mdata}, inum in the MSBs.
  function automatic int rec_w(int data_w, int reg_w, int cnt_w);
    return 2 * cnt_w + KIND_W + 4 * data_w + reg_w;
  endfunction

  function automatic int off_addr(int data_w);
    return data_w;
  endfunction

  function automatic int off_wdata(int data_w);
    return 2 * data_w;
  endfunction

  function automatic int off_wreg(int data_w);
    return 3 * data_w;
  endfunction

  function automatic int off_pc(int data_w, int reg_w);
    return 3 * data_w + reg_w;
  endfunction

  function automatic int off_kind(int data_w, int reg_w);
    return 4 * data_w + reg_w;
  endfunction

  function automatic int off_cycle(int data_w, int reg_w);
    return 4 * data_w + reg_w + KIND_W;
  endfunction

  function automatic int off_inum(int data_w, int reg_w, int cnt_w);
    return 4 * data_w + reg_w + KIND_W + cnt_w;
  endfunction

  // Halt wins over everything; a load without a register write has no visible effect.
  function automatic kind_e classify(logic halt, logic regwrite, logic memread, logic memwrite);
    if (halt)                       return KIND_HALT;
    else if (regwrite && memwrite)  return KIND_STU;
    else if (regwrite && memread)   return KIND_LD;
    else if (regwrite)              return KIND_REG;
    else if (memwrite)              return KIND_ST;
    else                            return KIND_NOP;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - record FIFO with wrap-bit pointers and a head output driven only from stored state
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             empty_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer advance; the caller only pushes with space (or a same-cycle pop) and pops when non-empty.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; a push into a full FIFO overwrites exactly the slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  assign empty      = (wr_q == rd_q);
  assign full       = (wr_q == {~rd_q[AW], rd_q[AW-1:0]});
  assign empty_next = (wr_d == rd_d);
  assign head_data  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - classifies retiring instructions into trace records and queues them for a reader
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_W      = 3,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int TRACE_NOPS = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cm_valid,
  input  logic [DATA_W-1:0]                       cm_pc,
  input  logic                                    cm_regwrite,
  input  logic [REG_W-1:0]                        cm_wreg,
  input  logic [DATA_W-1:0]                       cm_wdata,
  input  logic                                    cm_memread,
  input  logic                                    cm_memwrite,
  input  logic [DATA_W-1:0]                       cm_addr,
  input  logic [DATA_W-1:0]                       cm_mdata,
  input  logic                                    cm_halt,
  output logic                                    tr_valid,
  input  logic                                    tr_ready,
  output logic [rec_w(DATA_W, REG_W, CNT_W)-1:0]  tr_record,
  output logic [CNT_W-1:0]                        cycle_count,
  output logic [CNT_W-1:0]                        inst_count,
  output logic [CNT_W-1:0]                        drop_count,
  output logic                                    overflow,
  output logic                                    halted,
  output logic                                    done
);

  localparam int REC_W     = rec_w(DATA_W, REG_W, CNT_W);
  localparam int OFF_ADDR  = off_addr(DATA_W);
  localparam int OFF_WDATA = off_wdata(DATA_W);
  localparam int OFF_WREG  = off_wreg(DATA_W);
  localparam int OFF_PC    = off_pc(DATA_W, REG_W);
  localparam int OFF_KIND  = off_kind(DATA_W, REG_W);
  localparam int OFF_CYCLE = off_cycle(DATA_W, REG_W);
  localparam int OFF_INUM  = off_inum(DATA_W, REG_W, CNT_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
  logic             overflow_q, overflow_d;

  kind_e            kind;
  logic             accept, push_req, pop, fifo_push, drop;
  logic             fifo_full, fifo_empty, fifo_empty_next;
  logic [REC_W-1:0] rec;

  // Classify the commit, decide push/drop against FIFO occupancy and pack the record.
  always_comb begin
    kind      = classify(cm_halt, cm_regwrite, cm_memread, cm_memwrite);
    accept    = cm_valid && (state_q == ST_RUN);
    push_req  = accept && ((kind != KIND_NOP) || (TRACE_NOPS != 0));
    pop       = !fifo_empty && tr_ready;
    fifo_push = push_req && (!fifo_full || pop);
    drop      = push_req && fifo_full && !pop;
    rec                          = '0;
    rec[0 +: DATA_W]             = cm_mdata;
    rec[OFF_ADDR +: DATA_W]      = cm_addr;
    rec[OFF_WDATA +: DATA_W]     = cm_wdata;
    rec[OFF_WREG +: REG_W]       = cm_wreg;
    rec[OFF_PC +: DATA_W]        = cm_pc;
    rec[OFF_KIND +: KIND_W]      = kind;
    rec[OFF_CYCLE +: CNT_W]      = cycle_q;
    rec[OFF_INUM +: CNT_W]       = inst_q;
  end

  // Counters and run/halt FSM next state; the cycle stamp stops on the cycle the halt commits.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    inst_d     = inst_q + CNT_W'(accept);
    drop_d     = drop_q + CNT_W'(drop);
    overflow_d = overflow_q || drop;
    case (state_q)
      ST_RUN: begin
        if (accept && cm_halt) state_d = ST_HALTED;
        else                   cycle_d = cycle_q + CNT_W'(1);
      end
      // Look at next-cycle occupancy so done rises the cycle right after the last pop.
      ST_HALTED: if (fifo_empty_next) state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = state_q;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      cycle_q    <= '0;
      inst_q     <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push       (fifo_push),
    .push_data  (rec),
    .pop        (pop),
    .head_data  (tr_record),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next)
  );

  assign tr_valid    = !fifo_empty;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign overflow    = overflow_q;
  assign halted      = (state_q != ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable, parametrised capture of the processor commit stream.
- Each retiring instruction's architectural effect (register write, memory read or write, halt) is packed into a trace record with an instruction number and cycle stamp.
- Records are buffered in a FIFO and drained over a valid/ready port to a host/debug reader.
- The block sits beside the writeback stage and replaces purely simulation-side tracing, so traces survive FPGA runs and pipelined commit.

Parameters:
DATA_W, 16, width of PC, register data, memory address and memory data
REG_W, 3, register-select width
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, 32, width of cycle counter, instruction counter and drop counter
TRACE_NOPS, 1, 1 records commits with no side effect (branch/NOP); 0 counts them but does not record them

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
cm_valid  in  1  one instruction commits this cycle
cm_pc  in  DATA_W  PC of committing instruction
cm_regwrite  in  1  register file written
cm_wreg  in  REG_W  destination register
cm_wdata  in  DATA_W  register write data
cm_memread  in  1  load
cm_memwrite  in  1  store
cm_addr  in  DATA_W  memory address
cm_mdata  in  DATA_W  store data
cm_halt  in  1  halt commits
tr_valid  out  1  record available
tr_ready  in  1  reader accepts record
tr_record  out  REC_W  packed record {inum, cycle, kind, pc, wreg, wdata, addr, mdata}
cycle_count  out  CNT_W  cycles since reset
inst_count  out  CNT_W  committed instructions
drop_count  out  CNT_W  records lost to full FIFO
overflow  out  1  sticky: at least one record dropped
halted  out  1  halt has committed
done  out  1  halted and FIFO empty

Behaviour:
- Reset (rst low, asynchronous): all counters 0; FIFO empty; tr_valid=0; overflow=0; halted=0; done=0; state RUN. tr_record is don't-care while tr_valid=0.
- cycle_count increments every clock while not halted and freezes on the cycle halt commits. Wraps modulo 2^CNT_W.
- Kind encoding:
  - HALT if cm_halt.
  - Else STU if regwrite & memwrite.
  - Else LD if regwrite & memread.
  - Else REG if regwrite.
  - Else ST if memwrite.
  - Else NOP.
  - cm_memread without regwrite is classified NOP.
- Commit accepted = cm_valid & state RUN.
  - On accept, inst_count increments; the record's inum is the pre-increment value, so the first instruction is inum 0.
  - The record's cycle field is the current cycle_count.
- Record pushed = accept & (kind != NOP | TRACE_NOPS).
  - HALT is always pushed.
- Push when full:
  - Without a same-cycle pop: record discarded, drop_count+1, overflow set.
  - With a same-cycle pop (tr_valid & tr_ready): push succeeds.
- Pop when tr_valid & tr_ready; the head advances next cycle.
- Read latency: tr_record and tr_valid are registered from FIFO state. A record pushed in cycle N is visible at tr_valid in cycle N+1.
- tr_record must stay stable while tr_valid=1 & tr_ready=0.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full/empty are distinguished by the MSB.
- FSM:
  - RUN -> HALTED on accepted halt.
  - HALTED -> DONE when the FIFO is empty.
  - DONE holds until reset.
  - In HALTED/DONE, cm_valid is ignored (no count, no push).
- halted = state != RUN. done = state DONE.
- A halt dropped on full still moves the FSM to HALTED.
- overflow is cleared only by reset.

Decomposition:
- Package commit_trace_pkg:
  - kind codes (3 bits: NOP, REG, LD, ST, STU, HALT)
  - FSM state encoding
  - REC_W function of parameters: 2*CNT_W + 3 + 4*DATA_W + REG_W
  - record field offsets
- One sub-module: trace_fifo (DEPTH x REC_W, synchronous push/pop, full/empty, registered head output).
- Classification, counters and FSM stay in the top.

Test Plan:
- Reset then three REG commits (pc 0x0000/0x0002/0x0004, r1=0x1234) with tr_ready=1 -> three records, inum 0,1,2, kind REG, wdata 0x1234; inst_count=3.
- LD (addr 0x0040) then STU (addr 0x0042, mdata 0xBEEF) -> kinds LD, STU; ADDR and mdata fields match the inputs.
- TRACE_NOPS=0, pattern REG, NOP, REG -> two records with inum 0 and 2; inst_count=3.
- DEPTH=4, tr_ready=0, six commits -> four stored, drop_count=2, overflow=1.
  - Then raise tr_ready -> inums 0-3 drain in order.
- Full FIFO with simultaneous push and pop -> no drop; record count stays 4.
- Halt at cycle 10 with 2 records queued, tr_ready=1:
  - halted=1 next cycle; cycle_count frozen at 10.
  - Later cm_valid is ignored.
  - done=1 the cycle after the HALT record is popped.
- rst low mid-drain -> all outputs return to reset values immediately, asynchronously.
